// File: rtl/lcd_capture.sv
// Parallel RGB565 LCD sink: recovers pixel x/y from DEN/VSYNC, checks frame geometry,
// locks after consecutive good frames and writes thresholded 1-bit pixels to a 64Kx1 buffer.
module lcd_capture #(
    parameter int unsigned H_ACTIVE    = 480,
    parameter int unsigned V_ACTIVE    = 272,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned THRESH      = 94,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vsync,
    input  logic        i_den,
    input  logic [4:0]  i_r,
    input  logic [5:0]  i_g,
    input  logic [4:0]  i_b,
    output logic        o_wr_en,
    output logic [15:0] o_wr_addr,
    output logic        o_wr_data,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_err,
    output logic [9:0]  o_line_len,
    output logic [9:0]  o_line_cnt
);

    localparam logic [9:0] HLen    = 10'(H_ACTIVE);
    localparam logic [9:0] VLen    = 10'(V_ACTIVE);
    localparam logic [7:0] LumaMin = 8'(THRESH);
    localparam logic [2:0] LockCnt = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StMeasure = 2'd1,
        StLocked  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_vs1;
    logic       r_vs1_p;
    logic       r_den1;
    logic       r_den1_p;
    logic [4:0] r_r1;
    logic [5:0] r_g1;
    logic [4:0] r_b1;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [2:0] r_good;
    logic       r_bad;
    logic       r_skip;

    logic       w_vs_lead;
    logic       w_den_rise;
    logic       w_den_fall;
    logic       w_den_across;
    logic [9:0] w_px_x;
    logic [9:0] w_px_y;
    logic [9:0] w_x_next;
    logic [9:0] w_y_inc;
    logic [9:0] w_lines;
    logic       w_line_inc;
    logic       w_line_bad;
    logic       w_frame_bad;
    logic [2:0] w_good_inc;
    logic       w_to_locked;
    logic       w_drop;
    logic       w_locked_next;
    logic [7:0] w_luma;
    logic       w_pix;
    logic       w_wr;

    // VSYNC normalised to active-high at the input register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs1    <= 1'b0;
            r_vs1_p  <= 1'b0;
            r_den1   <= 1'b0;
            r_den1_p <= 1'b0;
            r_r1     <= '0;
            r_g1     <= '0;
            r_b1     <= '0;
        end else begin
            r_vs1    <= (i_vsync == VSYNC_POL);
            r_vs1_p  <= r_vs1;
            r_den1   <= i_den;
            r_den1_p <= r_den1;
            r_r1     <= i_r;
            r_g1     <= i_g;
            r_b1     <= i_b;
        end
    end

    assign w_vs_lead    = r_vs1 & ~r_vs1_p;
    assign w_den_rise   = r_den1 & ~r_den1_p;
    assign w_den_fall   = ~r_den1 & r_den1_p;
    assign w_den_across = r_den1 & r_den1_p;

    // Frame end is handled before a coincident DEN rise, so that pixel lands on x=0, y=0
    assign w_px_x   = w_den_rise ? '0 : r_x;
    assign w_px_y   = w_vs_lead ? '0 : r_y;
    assign w_x_next = (&w_px_x) ? w_px_x : w_px_x + 10'd1;
    assign w_y_inc  = (&r_y) ? r_y : r_y + 10'd1;

    // A line that straddled the VSYNC edge is excluded from the new frame's line count
    assign w_line_inc  = w_den_fall & ~r_skip;
    assign w_line_bad  = w_line_inc & (r_x != HLen);
    assign w_lines     = w_line_inc ? w_y_inc : r_y;
    assign w_frame_bad = r_bad | w_line_bad | (w_lines != VLen);
    assign w_good_inc  = r_good + 3'd1;

    assign w_to_locked   = (r_state == StMeasure) & w_vs_lead & ~w_frame_bad &
                           (w_good_inc == LockCnt);
    assign w_drop        = (r_state == StLocked) & (w_line_bad | (w_vs_lead & w_frame_bad));
    assign w_locked_next = w_to_locked | ((r_state == StLocked) & ~w_drop);

    assign w_luma = {2'b00, r_r1, 1'b0} + {2'b00, r_g1} + {2'b00, r_b1, 1'b0};
    assign w_pix  = (w_luma >= LumaMin);
    assign w_wr   = w_locked_next & r_den1 & ~w_px_x[0] & (w_px_y[9:8] == 2'b00);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_bad         <= 1'b0;
            r_skip        <= 1'b0;
            o_line_len    <= '0;
            o_line_cnt    <= '0;
            o_frame_start <= 1'b0;
        end else begin
            if (r_den1) begin
                r_x <= w_x_next;
            end
            if (w_vs_lead) begin
                r_y    <= '0;
                r_skip <= w_den_across;
                r_bad  <= w_den_across;
            end else begin
                if (w_line_inc) begin
                    r_y <= w_y_inc;
                end
                if (w_den_fall) begin
                    r_skip <= 1'b0;
                end
                if (w_line_bad) begin
                    r_bad <= 1'b1;
                end
            end
            if (w_den_fall) begin
                o_line_len <= r_x;
            end
            if (w_vs_lead) begin
                o_line_cnt <= w_lines;
            end
            o_frame_start <= w_vs_lead;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StSearch;
            r_good    <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= 1'b0;
        end else begin
            o_locked <= w_locked_next;
            o_err    <= w_drop;
            o_wr_en  <= w_wr;
            if (w_wr) begin
                o_wr_addr <= {w_px_y[7:0], w_px_x[8:1]};
                o_wr_data <= w_pix;
            end
            unique case (r_state)
                StSearch: begin
                    r_good <= '0;
                    if (w_vs_lead) begin
                        r_state <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (w_vs_lead) begin
                        if (w_frame_bad) begin
                            r_good <= '0;
                        end else if (w_to_locked) begin
                            r_good  <= '0;
                            r_state <= StLocked;
                        end else begin
                            r_good <= w_good_inc;
                        end
                    end
                end
                StLocked: begin
                    if (w_drop) begin
                        r_good  <= '0;
                        r_state <= StSearch;
                    end
                end
                default: begin
                    r_good  <= '0;
                    r_state <= StSearch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
// Scoreboard bench for lcd_capture on a reduced 6x258 geometry: lock, threshold, line
// error, short frame, saturating long line and mid-line reset with relock.
module tb_lcd_capture;

    localparam int H  = 6;
    localparam int V  = 258;
    localparam int HB = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_vsync;
    logic        i_den;
    logic [4:0]  i_r;
    logic [5:0]  i_g;
    logic [4:0]  i_b;
    logic        o_wr_en;
    logic [15:0] o_wr_addr;
    logic        o_wr_data;
    logic        o_frame_start;
    logic        o_locked;
    logic        o_err;
    logic [9:0]  o_line_len;
    logic [9:0]  o_line_cnt;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          n_fs       = 0;
    int          n_errp     = 0;
    int          prev_lines = 0;
    int          prev_len   = 0;
    logic [16:0] sb_q[$];

    lcd_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .VSYNC_POL   (1'b0),
        .THRESH      (94),
        .LOCK_FRAMES (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_vsync       (i_vsync),
        .i_den         (i_den),
        .i_r           (i_r),
        .i_g           (i_g),
        .i_b           (i_b),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_line_len    (o_line_len),
        .o_line_cnt    (o_line_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe
    always @(negedge i_clk) begin
        logic [16:0] e;
        if (o_frame_start === 1'b1) n_fs++;
        if (o_err === 1'b1) n_errp++;
        if (o_wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %h data %b with nothing expected",
                         o_wr_addr, o_wr_data);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(o_wr_addr), 32'(e[16:1]));
                check("wr_data", 32'(o_wr_data), 32'(e[0]));
            end
        end
    end

    // Pattern by pixel pair: white(187)=1, 15/31/15(91)=0, 16/31/16(95)=1, black=0
    task automatic colour(input bit pat, input int i, output logic [4:0] cr,
                          output logic [5:0] cg, output logic [4:0] cb, output logic cd);
        int p;
        p = pat ? ((i >> 1) % 4) : 0;
        case (p)
            0:       begin cr = 5'd31; cg = 6'd63; cb = 5'd31; cd = 1'b1; end
            1:       begin cr = 5'd15; cg = 6'd31; cb = 5'd15; cd = 1'b0; end
            2:       begin cr = 5'd16; cg = 6'd31; cb = 5'd16; cd = 1'b1; end
            default: begin cr = 5'd0;  cg = 6'd0;  cb = 5'd0;  cd = 1'b0; end
        endcase
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_den = 1'b0;
        end
    endtask

    task automatic vsync_pulse();
        @(negedge i_clk);
        i_vsync = 1'b0;
        i_den   = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_vsync = 1'b1;
        idle(3);
    endtask

    // ev_line: line with length ev_len, or (rst_pix >= 0) the line where reset hits at rst_pix
    task automatic send_frame(input int nlines, input bit pat, input bit exp_lock, input bit wr,
                              input int ev_line, input int ev_len, input int rst_pix);
        int         len;
        int         px;
        bit         do_wr;
        logic [4:0] cr;
        logic [5:0] cg;
        logic [4:0] cb;
        logic       cd;
        vsync_pulse();
        check("line_cnt", 32'(o_line_cnt), 32'(prev_lines));
        check("line_len", 32'(o_line_len), 32'(prev_len));
        check("locked", 32'(o_locked), 32'(exp_lock));
        for (int y = 0; y < nlines; y++) begin
            len = (y == ev_line && rst_pix < 0) ? ev_len : H;
            for (int i = 0; i < len; i++) begin
                @(negedge i_clk);
                colour(pat, i, cr, cg, cb, cd);
                i_den = 1'b1;
                i_r   = cr;
                i_g   = cg;
                i_b   = cb;
                px    = (i < 1023) ? i : 1023;
                do_wr = wr && (ev_line < 0 || y < ev_line ||
                               (y == ev_line && (rst_pix < 0 || i <= rst_pix - 2)));
                if (do_wr && (px % 2 == 0) && y < 256) begin
                    sb_q.push_back({8'(y), 8'(px >> 1), cd});
                end
                if (y == ev_line && i == rst_pix) begin
                    #2 i_rst = 1'b1;
                    #1;
                    check("rst_locked", 32'(o_locked), 32'(0));
                    check("rst_wr_en", 32'(o_wr_en), 32'(0));
                    check("rst_line_len", 32'(o_line_len), 32'(0));
                    check("rst_line_cnt", 32'(o_line_cnt), 32'(0));
                    repeat (3) @(negedge i_clk);
                    i_den = 1'b0;
                    @(negedge i_clk);
                    i_rst = 1'b0;
                    check("rst_pending", 32'(sb_q.size()), 32'(0));
                    prev_lines = 0;
                    prev_len   = 0;
                    return;
                end
            end
            for (int j = 0; j < HB; j++) begin
                @(negedge i_clk);
                i_den = 1'b0;
                if (y == ev_line && exp_lock) begin
                    if (j == 1) check("err_early", 32'(o_err), 32'(0));
                    if (j == 2) begin
                        check("err_pulse", 32'(o_err), 32'(1));
                        check("err_unlock", 32'(o_locked), 32'(0));
                        check("err_line_len", 32'(o_line_len), 32'((ev_len < 1023) ? ev_len : 1023));
                    end
                    if (j == 3) check("err_one_cycle", 32'(o_err), 32'(0));
                end
            end
        end
        prev_lines = nlines;
        prev_len   = H;
    endtask

    initial begin
        i_rst   = 1'b1;
        i_vsync = 1'b1;
        i_den   = 1'b0;
        i_r     = '0;
        i_g     = '0;
        i_b     = '0;
        repeat (3) @(negedge i_clk);
        check("reset_wr_en", 32'(o_wr_en), 32'(0));
        check("reset_wr_addr", 32'(o_wr_addr), 32'(0));
        check("reset_wr_data", 32'(o_wr_data), 32'(0));
        check("reset_frame_start", 32'(o_frame_start), 32'(0));
        check("reset_locked", 32'(o_locked), 32'(0));
        check("reset_err", 32'(o_err), 32'(0));
        check("reset_line_len", 32'(o_line_len), 32'(0));
        check("reset_line_cnt", 32'(o_line_cnt), 32'(0));
        i_rst = 1'b0;
        idle(4);

        send_frame(V,     0, 0, 0, -1, 0, -1);     // F1: first edge, measure
        send_frame(V,     0, 0, 0, -1, 0, -1);     // F2
        send_frame(V,     0, 1, 1, -1, 0, -1);     // F3: locked, white
        send_frame(V,     1, 1, 1, -1, 0, -1);     // F4: threshold pattern
        send_frame(V,     1, 1, 1, 5, H - 1, -1);  // F5: short line drops lock
        send_frame(V,     1, 0, 0, -1, 0, -1);     // F6: search -> measure
        send_frame(V - 1, 1, 0, 0, -1, 0, -1);     // F7: one line short
        send_frame(V,     1, 0, 0, -1, 0, -1);     // F8: good count restarted
        send_frame(V,     1, 0, 0, -1, 0, -1);     // F9
        send_frame(V,     1, 1, 1, -1, 0, -1);     // F10: relocked
        send_frame(V,     1, 1, 1, 0, 1100, -1);   // F11: saturating long line
        send_frame(V,     1, 0, 0, -1, 0, -1);     // F12
        send_frame(V,     1, 0, 0, -1, 0, -1);     // F13
        send_frame(V,     1, 1, 1, 3, 0, 4);       // F14: reset mid-line
        send_frame(V,     1, 0, 0, -1, 0, -1);     // F15
        send_frame(V,     1, 0, 0, -1, 0, -1);     // F16
        send_frame(V,     1, 1, 1, -1, 0, -1);     // F17: relocked after reset
        vsync_pulse();
        check("final_line_cnt", 32'(o_line_cnt), 32'(V));
        check("final_locked", 32'(o_locked), 32'(1));
        idle(4);
        check("pending_writes", 32'(sb_q.size()), 32'(0));
        check("frame_starts", 32'(n_fs), 32'(18));
        check("err_pulses", 32'(n_errp), 32'(2));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
